lsu_hs: RTL and testbench

- Parametrised load/store unit for the pipelined RV core, with a valid/ready handshake.
- Sits between the execute stage, which issues one memory op per handshake, and the data-memory bus, which uses a request/grant handshake and a separate read-response strobe.
- Adds over the single-cycle LSU: XLEN generalisation (32/64), variable memory wait states, misaligned-access detection, and a bus-timeout error response.

---
 rtl/lsu_hs.sv | 195 +++++++++++++++++++
 tb/tb_lsu_hs.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_hs.sv
`default_nettype none
// ============================================================================
// Module  : lsu_hs
// Brief   : Load/store unit with valid/ready op intake, req/gnt data bus,
//           misalign detection and bus-timeout error response.
// Rev     : 1.0
// ============================================================================
module lsu_hs #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [4:0]          resp_rd,
  output logic                resp_err,
  output logic                resp_misalign,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_off;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [CNT_W-1:0] r_cnt;

  logic [OFF_W-1:0] w_off;
  logic [OFF_W-1:0] w_amask;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_expire;
  logic [NB-1:0]    w_base;
  logic [NB-1:0]    w_be;
  logic [XLEN-1:0]  w_lane_mask;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_ext;

  assign w_off      = req_addr[OFF_W-1:0];
  assign w_amask    = OFF_W'((4'd1 << req_size) - 4'd1);
  assign w_illegal  = (XLEN == 32) && (req_size == 2'b11);
  assign w_misalign = (w_off & w_amask) != '0;
  // Counter may sit at TIMEOUT after a last-cycle grant, hence >= rather than ==.
  assign w_expire   = r_cnt >= CNT_W'(TIMEOUT - 1);

  always_comb begin
    w_base = '0;
    case (req_size)
      2'b00:   w_base = NB'(1);
      2'b01:   w_base = NB'(3);
      2'b10:   w_base = NB'(15);
      default: w_base = NB'(8'hFF);
    endcase
  end

  assign w_be = w_base << w_off;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_lane_mask[8*i +: 8] = {8{w_be[i]}};
  end

  assign w_wdata   = (req_wdata << {w_off, 3'b000}) & w_lane_mask;
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
      2'b01:   w_ext = r_unsigned ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
      2'b10:   w_ext = r_unsigned ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_off         <= '0;
      r_size        <= '0;
      r_unsigned    <= 1'b0;
      r_cnt         <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_rd       <= '0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            resp_rd    <= req_rd;
            r_off      <= w_off;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_cnt      <= '0;
            mem_we     <= req_store;
            if (w_illegal) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (w_misalign) begin
              r_state       <= S_RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (mem_we) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_expire) begin
            mem_req    <= 1'b0;
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_ext;
          end else if (w_expire) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state       <= S_IDLE;
          req_ready     <= 1'b1;
          resp_valid    <= 1'b0;
          resp_rdata    <= '0;
          resp_err      <= 1'b0;
          resp_misalign <= 1'b0;
          r_cnt         <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_hs
// Brief   : Self-checking bench for lsu_hs at XLEN=32 and XLEN=64.
// Rev     : 1.0
// ============================================================================
module tb_lsu_hs;
  localparam int T32 = 15;
  localparam int T64 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        a_ready, a_rv, a_err, a_mis, a_mreq, a_we;
  logic [31:0] a_rdata, a_maddr, a_wd;
  logic [4:0]  a_rd;
  logic [3:0]  a_be;
  logic        b_ready, b_rv, b_err, b_mis, b_mreq, b_we;
  logic [63:0] b_rdata, b_wd;
  logic [31:0] b_maddr;
  logic [4:0]  b_rd;
  logic [7:0]  b_be;

  lsu_hs #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_ready), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_rd(a_rd), .resp_err(a_err),
    .resp_misalign(a_mis), .mem_req(a_mreq), .mem_we(a_we), .mem_addr(a_maddr),
    .mem_be(a_be), .mem_wdata(a_wd), .mem_gnt(mem_gnt & ~sel),
    .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata[31:0])
  );

  lsu_hs #(.XLEN(64), .ADDR_W(32), .TIMEOUT(T64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_rd(b_rd), .resp_err(b_err),
    .resp_misalign(b_mis), .mem_req(b_mreq), .mem_we(b_we), .mem_addr(b_maddr),
    .mem_be(b_be), .mem_wdata(b_wd), .mem_gnt(mem_gnt & sel),
    .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata)
  );

  logic        o_ready, o_rv, o_err, o_mis, o_mreq, o_we;
  logic [63:0] o_rdata, o_wd;
  logic [31:0] o_maddr;
  logic [4:0]  o_rd;
  logic [7:0]  o_be;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_err   = sel ? b_err   : a_err;
  assign o_mis   = sel ? b_mis   : a_mis;
  assign o_mreq  = sel ? b_mreq  : a_mreq;
  assign o_we    = sel ? b_we    : a_we;
  assign o_rdata = sel ? b_rdata : {32'h0, a_rdata};
  assign o_wd    = sel ? b_wd    : {32'h0, a_wd};
  assign o_maddr = sel ? b_maddr : a_maddr;
  assign o_rd    = sel ? b_rd    : a_rd;
  assign o_be    = sel ? b_be    : {4'h0, a_be};

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int xlen, tmo, op_cyc;
  bit chk_en = 1'b0;

  // Expected per-cycle view, filled by the stimulus side from the model.
  logic        exp_ready, exp_mreq, exp_rv, exp_we, exp_err, exp_mis;
  logic [31:0] exp_addr;
  logic [7:0]  exp_be;
  logic [63:0] exp_wd, exp_rdata;
  logic [4:0]  exp_rd;

  int          last_resp_cyc;
  logic [63:0] last_rdata, last_wd;
  logic [31:0] last_maddr;
  logic [7:0]  last_be;
  logic [4:0]  last_rd;
  logic        last_err, last_mis, last_we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", o_ready, exp_ready);
      check("mem_req", o_mreq, exp_mreq);
      check("resp_valid", o_rv, exp_rv);
      if (exp_mreq) begin
        check("mem_we", o_we, exp_we);
        check("mem_addr", o_maddr, exp_addr);
        check("mem_be", o_be, exp_be);
        check("mem_wdata", o_wd, exp_wd);
      end
      if (exp_rv) begin
        check("resp_rdata", o_rdata, exp_rdata);
        check("resp_rd", o_rd, exp_rd);
        check("resp_err", o_err, exp_err);
        check("resp_misalign", o_mis, exp_mis);
      end
      if (o_mreq) begin
        last_be = o_be; last_maddr = o_maddr; last_wd = o_wd; last_we = o_we;
      end
      if (o_rv) begin
        last_resp_cyc = op_cyc; last_rdata = o_rdata; last_rd = o_rd;
        last_err = o_err; last_mis = o_mis;
      end
    end
  end

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_mreq = 1'b0; exp_rv = 1'b0;
  endtask

  task automatic idle(input int n, input bit pulse);
    for (int i = 0; i < n; i++) begin
      set_idle_exp();
      req_valid = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = pulse ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  // g: REQ cycle (1-based) in which the bus grants; v: WAIT cycle delivering data.
  task automatic do_op(input logic [31:0] addr, input logic [63:0] wdata, input bit store,
                       input logic [1:0] size, input bit uns, input logic [4:0] rd,
                       input int g, input int v, input logic [63:0] rdata);
    int nb, off, n, rc, eerr;
    bit illegal, mis, legal, terr;
    logic [63:0] rd_t, val, msk, wd_t;
    logic [7:0]  be_t;
    nb = xlen / 8;
    off = int'(addr & 32'(nb - 1));
    n = 1 << size;
    illegal = (xlen == 32) && (size == 2'b11);
    mis = !illegal && (off % n != 0);
    legal = !illegal && !mis;
    terr = 1'b0;
    if (!legal) rc = 1;
    else if (g > tmo) begin rc = tmo + 1; terr = 1'b1; end
    else if (store) rc = g + 1;
    else if (v == 1 || g + v - 1 < tmo) rc = g + v + 1;
    else begin
      eerr = (g + 1 > tmo) ? g + 1 : tmo;
      rc = eerr + 1; terr = 1'b1;
    end
    rd_t = (xlen == 32) ? {32'h0, rdata[31:0]} : rdata;
    val = rd_t >> (8 * off);
    if (n < 8) begin
      msk = (64'd1 << (8 * n)) - 64'd1;
      val = val & msk;
      if (!uns && val[8*n-1]) val = val | ~msk;
    end
    if (xlen == 32) val[63:32] = 32'h0;
    be_t = 8'h0; wd_t = 64'h0;
    for (int i = 0; i < nb; i++) begin
      if (i >= off && i < off + n) begin
        be_t[i] = 1'b1;
        wd_t[8*i +: 8] = wdata[8*(i-off) +: 8];
      end
    end
    exp_we = store; exp_addr = addr & ~32'(nb - 1); exp_be = be_t; exp_wd = wd_t;
    exp_rdata = (legal && !store && !terr) ? val : 64'h0;
    exp_err = illegal || terr; exp_mis = mis; exp_rd = rd;
    last_resp_cyc = -1;
    op_cyc = 0;
    set_idle_exp();
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_store = store;
    req_size = size; req_unsigned = uns; req_rd = rd;
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 3) == 0); mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_store = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1)); req_rd = 5'($urandom);
    for (int c = 1; c <= rc; c++) begin
      op_cyc = c;
      exp_ready = 1'b0;
      exp_mreq = legal && (c <= g) && (c <= tmo);
      exp_rv = (c == rc);
      mem_gnt = legal && (c == g) && (c <= tmo);
      mem_rvalid = (legal && !store && c == g + v) || (c <= g && $urandom_range(0, 3) == 0);
      mem_rdata = (c == g + v) ? rdata : {$urandom, $urandom};
      @(posedge clk); #1;
    end
    op_cyc = rc + 1;
    set_idle_exp();
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
  endtask

  task automatic rand_ops(input int count);
    logic [31:0] a;
    logic [1:0]  s;
    int g, v, r;
    for (int k = 0; k < count; k++) begin
      a = $urandom;
      if (xlen == 32) s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      else s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << s) - 1);
      r = $urandom_range(0, 9);
      g = (r == 0) ? tmo + 1 + $urandom_range(0, 3) : ((r < 6) ? 1 : $urandom_range(1, tmo));
      v = ($urandom_range(0, 4) == 0) ? $urandom_range(1, tmo + 2) : $urandom_range(1, 3);
      do_op(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
            5'($urandom), g, v, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b0);
    end
  endtask

  task automatic rst_test(input bit in_wait);
    op_cyc = 0;
    set_idle_exp();
    req_valid = 1'b1; req_addr = 32'h40; req_store = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_rd = 5'd3; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h40; exp_be = (xlen == 32) ? 8'h0F : 8'h0F;
    exp_wd = 64'h0; req_wdata = 64'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_ready = 1'b0; exp_mreq = 1'b1; exp_rv = 1'b0;
    mem_gnt = in_wait;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    set_idle_exp();
    @(negedge clk);
    check("rst_mem_addr", o_maddr, 32'h0);
    check("rst_mem_be", o_be, 8'h0);
    check("rst_mem_wdata", o_wd, 64'h0);
    check("rst_mem_we", o_we, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle(2, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; xlen = 32; tmo = T32; op_cyc = 0; last_resp_cyc = -1;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_store = 1'b0;
    req_size = '0; req_unsigned = 1'b0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0; exp_rdata = '0;
    exp_err = 1'b0; exp_mis = 1'b0; exp_rd = '0;
    set_idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_mem_addr", o_maddr, 32'h0);
    check("reset_resp_rdata", o_rdata, 64'h0);
    check("reset_resp_flags", {o_err, o_mis, o_we}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1'b0);

    do_op(32'h103, 64'h0, 1'b0, 2'b00, 1'b0, 5'd5, 1, 1, 64'h80AABBCC);
    check("lb_latency", last_resp_cyc, 3);
    check("lb_rdata", last_rdata, 64'hFFFFFF80);
    check("lb_rd", last_rd, 5'd5);
    check("lb_mem_be", last_be, 8'h08);
    check("lb_mem_addr", last_maddr, 32'h100);

    do_op(32'h202, 64'h1234ABCD, 1'b1, 2'b01, 1'b0, 5'd7, 1, 1, 64'h0);
    check("sh_latency", last_resp_cyc, 2);
    check("sh_mem_we", last_we, 1'b1);
    check("sh_mem_be", last_be, 8'h0C);
    check("sh_mem_wdata", last_wd, 64'hABCD0000);
    check("sh_rdata", last_rdata, 64'h0);

    do_op(32'h101, 64'h0, 1'b0, 2'b10, 1'b0, 5'd9, 1, 1, 64'h0);
    check("lw_mis_latency", last_resp_cyc, 1);
    check("lw_mis_flag", {last_mis, last_err}, 2'b10);

    do_op(32'h102, 64'h0, 1'b0, 2'b01, 1'b1, 5'd10, 2, 3, 64'hF00D0000);
    check("lhu_rdata", last_rdata, 64'h0000F00D);
    check("lhu_latency", last_resp_cyc, 6);

    do_op(32'h40, 64'h0, 1'b0, 2'b10, 1'b0, 5'd11, 99, 1, 64'h0);
    check("tmo_latency", last_resp_cyc, 16);
    check("tmo_flags", {last_err, last_mis}, 2'b10);
    check("tmo_rdata", last_rdata, 64'h0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    do_op(32'h80, 64'h0, 1'b0, 2'b11, 1'b0, 5'd12, 1, 1, 64'h0);
    check("illegal_latency", last_resp_cyc, 1);
    check("illegal_err", last_err, 1'b1);

    rand_ops(40);
    rst_test(1'b1);
    rst_test(1'b0);
    rand_ops(10);

    sel = 1'b1; xlen = 64; tmo = T64;
    idle(2, 1'b0);
    do_op(32'h8, 64'h0, 1'b0, 2'b11, 1'b0, 5'd13, 1, 1, 64'h0123456789ABCDEF);
    check("ld_rdata", last_rdata, 64'h0123456789ABCDEF);
    do_op(32'h4, 64'h0, 1'b0, 2'b10, 1'b0, 5'd14, 1, 1, 64'h8000000100000000);
    check("lw64_rdata", last_rdata, 64'hFFFFFFFF80000001);
    rand_ops(40);
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
